programmable_clock_divider: RTL and testbench
=============================================

PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8: divisor width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 2: divisor after reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk_in  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous active-low reset.
REQ-005 SHALL have port en  input  1: run request.
REQ-006 SHALL have port load  input  1: one-cycle strobe capturing div_val.
REQ-007 SHALL have port div_val  input  WIDTH: requested divisor N.
REQ-008 SHALL have port clk_out  output  1: divided clock, driven directly by a flop.
REQ-009 SHALL have port pend  output  1: a loaded divisor is waiting for a period boundary.
REQ-010 SHALL have port err  output  1: sticky illegal-divisor flag.
REQ-011 SHALL have port tick  output  1: one-cycle pulse per output period (see Configuration).

Function
REQ-012 SHALL implement states IDLE and RUN, a WIDTH-bit phase counter cnt, an active divisor N and a pending divisor P.
REQ-013 Period length SHALL be N clk_in cycles, with cnt running 0..N-1 in RUN.
REQ-014 clk_out SHALL be 1 in RUN cycles where cnt < HI, HI = (N+1)>>1, and 0 otherwise. Even N gives 50% duty; odd N is high one cycle longer than it is low.
REQ-015 IDLE->RUN SHALL occur on the edge where en=1 is sampled. In the next cycle cnt=0, clk_out=1 and tick=1.
REQ-016 In RUN, cnt SHALL increment by 1 per cycle and wrap from N-1 to 0. The wrap edge is the period boundary.
REQ-017 en=0 mid-period SHALL NOT truncate the period. At the boundary with en=0 the block SHALL go to IDLE with cnt=0 and clk_out=0. With en=1 it SHALL continue in RUN.
REQ-018 tick SHALL be 1 exactly in the cycle where cnt=0 in RUN, and 0 otherwise.
REQ-019 load=1 with div_val >= 2 SHALL write P and set pend=1 on that edge, in any state.
REQ-020 load=1 while pend=1 SHALL overwrite P. Last write wins.
REQ-021 At a period boundary, or while in IDLE, pend=1 SHALL copy P to N and clear pend. The first cycle of the new period uses the new N and HI.
REQ-022 load=1 with div_val of 0 or 1 SHALL set err=1 and leave N, P and pend unchanged.
REQ-023 err SHALL clear only on reset.
REQ-024 load and a boundary on the same edge SHALL apply the old P, if any, at the boundary, then hold the new value pending until the next boundary.
REQ-025 clk_out SHALL never produce a high or low phase shorter than floor(N/2) cycles for the N in force.

Reset
REQ-026 reset_n=0 SHALL asynchronously force: state=IDLE, cnt=0, N=DEFAULT_DIV, P=DEFAULT_DIV, pend=0, err=0, clk_out=0, tick=0.
REQ-027 Reset assertion mid-period SHALL drop clk_out to 0 immediately, regardless of phase.
REQ-028 After deassertion the block SHALL stay in IDLE until en=1 is sampled on a rising clk_in edge.

Configuration
REQ-029 Macro PCLKDIV_TICK_EN SHALL control the tick feature.
REQ-030 With PCLKDIV_TICK_EN defined, the tick port and its logic SHALL exist per REQ-018.
REQ-031 Without PCLKDIV_TICK_EN, the tick port SHALL be absent and all other behaviour SHALL be unchanged.

Verification (WIDTH=8, DEFAULT_DIV=4, PCLKDIV_TICK_EN defined)
REQ-032 Reset, then en=1 held for 12 cycles -> clk_out pattern 1100 repeated 3 times; tick every 4th cycle, coincident with clk_out rising; pend=0, err=0.
REQ-033 load with div_val=5 while in IDLE, then en=1 -> pend for 1 cycle; clk_out pattern 11100 repeating; tick period 5.
REQ-034 Running at N=4, load div_val=6 at cnt=1 -> current period ends after 4 cycles; pend=1 until that boundary; then pattern 111000.
REQ-035 load div_val=1, then load div_val=0 -> err=1 and stays 1; N unchanged; clk_out pattern unchanged; pend=0.
REQ-036 en=0 at cnt=1 with N=4 -> remaining 3 cycles complete, then clk_out=0 in IDLE; en=1 again -> restarts at cnt=0, clk_out=1.
REQ-037 reset_n=0 asynchronously while clk_out=1 with N=6 -> clk_out=0 before the next clk_in edge; after release, N=4 and state IDLE.

Source files
------------

// File: rtl/programmable_clock_divider.sv
// Programmable integer clock divider with glitch-free divisor updates at period boundaries.
// Optional tick output (one pulse per period) is enabled by defining PCLKDIV_TICK_EN.
module programmable_clock_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             pend,
  output logic             err
`ifdef PCLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH:0]   n_plus1;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             clk_d;
  logic             load_ok, load_bad, boundary, apply;

  always_comb begin
    load_ok  = load && (div_val >= TWO);
    load_bad = load && !load_ok;
    boundary = (state_q == RUN) && (cnt_q == n_q - ONE);
    apply    = (state_q == IDLE) || boundary;

    // Pending divisor is promoted first; a load on the same edge then re-arms pend.
    n_d    = n_q;
    p_d    = p_q;
    pend_d = pend_q;
    if (apply && pend_q) begin
      n_d    = p_q;
      pend_d = 1'b0;
    end
    if (load_ok) begin
      p_d    = div_val;
      pend_d = 1'b1;
    end
    err_d = err_q | load_bad;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (boundary) begin
          cnt_d   = '0;
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // HI computed one bit wider so N = 2^WIDTH-1 does not overflow.
    n_plus1 = {1'b0, n_d} + {{WIDTH{1'b0}}, 1'b1};
    hi_d    = n_plus1[WIDTH:1];
    clk_d   = (state_d == RUN) && (cnt_d < hi_d);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= DEF_N;
      p_q     <= DEF_N;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      clk_out <= clk_d;
    end
  end

  assign pend = pend_q;
  assign err  = err_q;

`ifdef PCLKDIV_TICK_EN
  logic tick_d;
  assign tick_d = (state_d == RUN) && (cnt_d == '0);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) tick <= 1'b0;
    else          tick <= tick_d;
  end
`endif

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Directed bench for programmable_clock_divider (WIDTH=8, DEFAULT_DIV=4).
// Tick checks are active only when PCLKDIV_TICK_EN is defined.
module tb_programmable_clock_divider;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       en;
  logic       load;
  logic [7:0] div_val;
  logic       clk_out;
  logic       pend;
  logic       err;
`ifdef PCLKDIV_TICK_EN
  logic       tick;
`endif

  int checks = 0;
  int errors = 0;

  programmable_clock_divider #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (en),
    .load    (load),
    .div_val (div_val),
    .clk_out (clk_out),
    .pend    (pend),
    .err     (err)
`ifdef PCLKDIV_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; load = 1'b0; div_val = 8'd0;
    step(); step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk got %b exp 0", clk_out); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pend); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
`ifdef PCLKDIV_TICK_EN
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
`endif
    reset_n = 1'b1;
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 0", clk_out); end
  endtask

  task automatic test_run();
    logic exp_c, exp_t;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_c = (i % 4) < 2; exp_t = (i % 4) == 0;
      checks++; if (clk_out !== exp_c) begin errors++; $display("FAIL run4_clk i=%0d got %b exp %b", i, clk_out, exp_c); end
`ifdef PCLKDIV_TICK_EN
      checks++; if (tick !== exp_t) begin errors++; $display("FAIL run4_tick i=%0d got %b exp %b", i, tick, exp_t); end
`endif
      checks++; if (pend !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL run4_flags i=%0d got %b%b exp 00", i, pend, err); end
    end
    en = 1'b0;
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL run4_stop got %b exp 0", clk_out); end
  endtask

  task automatic test_idle_load();
    logic exp_c, exp_t;
    load = 1'b1; div_val = 8'd5;
    step();
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL idle_load_pend got %b exp 1", pend); end
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_c = (i % 5) < 3; exp_t = (i % 5) == 0;
      checks++; if (clk_out !== exp_c) begin errors++; $display("FAIL run5_clk i=%0d got %b exp %b", i, clk_out, exp_c); end
`ifdef PCLKDIV_TICK_EN
      checks++; if (tick !== exp_t) begin errors++; $display("FAIL run5_tick i=%0d got %b exp %b", i, tick, exp_t); end
`endif
      checks++; if (pend !== 1'b0) begin errors++; $display("FAIL run5_pend i=%0d got %b exp 0", i, pend); end
    end
    en = 1'b0;
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL run5_stop got %b exp 0", clk_out); end
    load = 1'b1; div_val = 8'd4;
    step();
    load = 1'b0;
    step();
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL restore4_pend got %b exp 0", pend); end
  endtask

  task automatic test_mid_load();
    logic exp_c;
    en = 1'b1;
    step();
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL mid_c0 got %b exp 1", clk_out); end
    step();
    load = 1'b1; div_val = 8'd6;
    step();
    load = 1'b0;
    checks++; if (pend !== 1'b1 || clk_out !== 1'b0) begin errors++; $display("FAIL mid_c2 got pend=%b clk=%b exp 1 0", pend, clk_out); end
    step();
    checks++; if (pend !== 1'b1 || clk_out !== 1'b0) begin errors++; $display("FAIL mid_c3 got pend=%b clk=%b exp 1 0", pend, clk_out); end
    for (int i = 0; i < 12; i++) begin
      step();
      exp_c = (i % 6) < 3;
      checks++; if (clk_out !== exp_c || pend !== 1'b0) begin errors++; $display("FAIL run6 i=%0d got clk=%b pend=%b exp %b 0", i, clk_out, pend, exp_c); end
`ifdef PCLKDIV_TICK_EN
      checks++; if (tick !== ((i % 6) == 0)) begin errors++; $display("FAIL run6_tick i=%0d got %b", i, tick); end
`endif
    end
    // load coinciding with the boundary edge: old N persists one more period
    load = 1'b1; div_val = 8'd4;
    step();
    load = 1'b0;
    checks++; if (pend !== 1'b1 || clk_out !== 1'b1) begin errors++; $display("FAIL bnd_load got pend=%b clk=%b exp 1 1", pend, clk_out); end
    for (int i = 1; i < 6; i++) begin
      step();
      exp_c = i < 3;
      checks++; if (clk_out !== exp_c || pend !== 1'b1) begin errors++; $display("FAIL bnd_hold i=%0d got clk=%b pend=%b exp %b 1", i, clk_out, pend, exp_c); end
    end
    step();
    checks++; if (clk_out !== 1'b1 || pend !== 1'b0) begin errors++; $display("FAIL bnd_apply got clk=%b pend=%b exp 1 0", clk_out, pend); end
    step();
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL back4_c1 got %b exp 1", clk_out); end
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL back4_c2 got %b exp 0", clk_out); end
  endtask

  task automatic test_err();
    logic exp_c;
    load = 1'b1; div_val = 8'd1;
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_div1 got %b exp 1", err); end
    div_val = 8'd0;
    step();
    load = 1'b0;
    checks++; if (err !== 1'b1 || pend !== 1'b0) begin errors++; $display("FAIL err_div0 got err=%b pend=%b exp 1 0", err, pend); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      exp_c = (i % 4) < 2;
      checks++; if (clk_out !== exp_c || err !== 1'b1 || pend !== 1'b0) begin errors++; $display("FAIL err_run i=%0d got clk=%b err=%b pend=%b exp %b 1 0", i, clk_out, err, pend, exp_c); end
    end
  endtask

  task automatic test_en_drop();
    logic exp_c [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++; if (clk_out !== exp_c[i]) begin errors++; $display("FAIL en_drop i=%0d got %b exp %b", i, clk_out, exp_c[i]); end
    end
`ifdef PCLKDIV_TICK_EN
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL idle_tick got %b exp 0", tick); end
`endif
    en = 1'b1;
    step();
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL restart_c0 got %b exp 1", clk_out); end
`ifdef PCLKDIV_TICK_EN
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL restart_tick got %b exp 1", tick); end
`endif
    step();
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL restart_c1 got %b exp 1", clk_out); end
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL restart_c2 got %b exp 0", clk_out); end
  endtask

  task automatic test_async_reset();
    logic exp_c;
    load = 1'b1; div_val = 8'd6;
    step();
    load = 1'b0;
    step();
    step();
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL n6_pre_reset got %b exp 1", clk_out); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL async_clk got %b exp 0", clk_out); end
    checks++; if (err !== 1'b0 || pend !== 1'b0) begin errors++; $display("FAIL async_flags got err=%b pend=%b exp 0 0", err, pend); end
    en = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b exp 0", clk_out); end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_c = (i % 4) < 2;
      checks++; if (clk_out !== exp_c) begin errors++; $display("FAIL post_reset_n4 i=%0d got %b exp %b", i, clk_out, exp_c); end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_idle_load();
    test_mid_load();
    test_err();
    test_en_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
